// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
//  Module   : riscv_ctrl_pkg
//  Purpose  : Opcode, FSM state and datapath-select encodings for control_unit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_halt   = 3'd5;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_j = 3'b011;
  localparam logic [2:0] c_imm_u = 3'b100;

  localparam logic [1:0] c_rf_alu = 2'b00;
  localparam logic [1:0] c_rf_dm  = 2'b01;
  localparam logic [1:0] c_rf_pc  = 2'b11;

  localparam logic [1:0] c_alu_add   = 2'b00;
  localparam logic [1:0] c_alu_sub   = 2'b01;
  localparam logic [1:0] c_alu_func  = 2'b10;
  localparam logic [1:0] c_alu_passb = 2'b11;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      c_op_r, c_op_imm, c_op_load, c_op_store, c_op_branch,
      c_op_jal, c_op_jalr, c_op_lui, c_op_auipc: opcode_known = 1'b1;
      default:                                   opcode_known = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
//  Module   : control_unit_if
//  Purpose  : Control bundle between the control unit and the RV64I datapath
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu;

  logic       load_IR, load_PC, we_RF, we_DM;
  logic       sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, sel_PC_RF;
  logic [2:0] sel_imme;
  logic [1:0] sel_RF_in;
  logic [1:0] alu_op;
  logic       instr_done, illegal;

  modport master (
    input  opcode, func3, flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu,
    output load_IR, load_PC, we_RF, we_DM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B,
           sel_PC_RF, sel_imme, sel_RF_in, alu_op, instr_done, illegal
  );

  modport slave (
    output opcode, func3, flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu,
    input  load_IR, load_PC, we_RF, we_DM, sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B,
           sel_PC_RF, sel_imme, sel_RF_in, alu_op, instr_done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
//  Module   : branch_cond
//  Purpose  : Selects the ALU compare flag named by a branch func3
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] i_func3,
  input  logic       i_flag_beq,
  input  logic       i_flag_bne,
  input  logic       i_flag_blt,
  input  logic       i_flag_bge,
  input  logic       i_flag_bltu,
  input  logic       i_flag_bgeu,
  output logic       o_taken,
  output logic       o_illegal_func3
);

  always_comb begin
    o_taken         = 1'b0;
    o_illegal_func3 = 1'b0;
    case (i_func3)
      c_f3_beq:  o_taken = i_flag_beq;
      c_f3_bne:  o_taken = i_flag_bne;
      c_f3_blt:  o_taken = i_flag_blt;
      c_f3_bge:  o_taken = i_flag_bge;
      c_f3_bltu: o_taken = i_flag_bltu;
      c_f3_bgeu: o_taken = i_flag_bgeu;
      default:   o_illegal_func3 = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  Module   : control_unit
//  Purpose  : Multicycle Moore FSM sequencing the RV64I datapath controls
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master cu
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       w_taken, w_bad_func3, w_legal, w_retire;
  logic       w_load_ir, w_load_pc, w_we_rf, w_we_dm;
  logic       w_sel_alu_a, w_sel_alu_b, w_sel_pc_a, w_sel_pc_b, w_sel_pc_rf;
  logic [2:0] w_sel_imme;
  logic [1:0] w_sel_rf_in, w_alu_op;
  logic       w_instr_done, w_illegal;

  branch_cond u_branch_cond (
    .i_func3        (cu.func3),
    .i_flag_beq     (cu.flag_beq),
    .i_flag_bne     (cu.flag_bne),
    .i_flag_blt     (cu.flag_blt),
    .i_flag_bge     (cu.flag_bge),
    .i_flag_bltu    (cu.flag_bltu),
    .i_flag_bgeu    (cu.flag_bgeu),
    .o_taken        (w_taken),
    .o_illegal_func3(w_bad_func3)
  );

  assign w_legal = opcode_known(cu.opcode) &&
                   !((cu.opcode == c_op_branch) && w_bad_func3);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_fetch;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = c_st_fetch;
    case (r_state)
      c_st_fetch:  w_next_state = c_st_decode;
      c_st_decode: w_next_state = (w_legal || !HALT_ON_ILLEGAL) ? c_st_exec : c_st_halt;
      c_st_exec: begin
        if (w_legal) begin
          case (cu.opcode)
            c_op_r, c_op_imm, c_op_lui: w_next_state = c_st_wb;
            c_op_load, c_op_store:      w_next_state = c_st_mem;
            default:                    w_next_state = c_st_fetch;
          endcase
        end
      end
      c_st_mem:  w_next_state = (cu.opcode == c_op_load) ? c_st_wb : c_st_fetch;
      c_st_halt: w_next_state = c_st_halt;
      default:   w_next_state = c_st_fetch;
    endcase
  end

  always_comb begin
    w_load_ir    = 1'b0;
    w_load_pc    = 1'b0;
    w_we_rf      = 1'b0;
    w_we_dm      = 1'b0;
    w_sel_alu_a  = 1'b0;
    w_sel_alu_b  = 1'b0;
    w_sel_pc_a   = 1'b0;
    w_sel_pc_b   = 1'b0;
    w_sel_pc_rf  = 1'b0;
    w_sel_imme   = c_imm_i;
    w_sel_rf_in  = c_rf_alu;
    w_alu_op     = c_alu_add;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;

    // Operand selects stay constant from EXEC through WB so the ALU result is stable at write-back
    if (w_legal && (r_state == c_st_exec || r_state == c_st_mem || r_state == c_st_wb)) begin
      case (cu.opcode)
        c_op_r:      begin w_sel_alu_a = 1'b1; w_sel_alu_b = 1'b1; w_alu_op = c_alu_func; end
        c_op_imm:    begin w_sel_alu_a = 1'b1; w_alu_op = c_alu_func; end
        c_op_load:   w_sel_alu_a = 1'b1;
        c_op_store:  begin w_sel_alu_a = 1'b1; w_sel_imme = c_imm_s; end
        c_op_branch: begin w_sel_alu_a = 1'b1; w_sel_alu_b = 1'b1; w_sel_imme = c_imm_b; end
        c_op_jal:    w_sel_imme = c_imm_j;
        c_op_lui:    begin w_sel_imme = c_imm_u; w_alu_op = c_alu_passb; end
        c_op_auipc:  w_sel_imme = c_imm_u;
        default: ;
      endcase
    end

    case (r_state)
      c_st_fetch: w_load_ir = 1'b1;
      c_st_exec: begin
        if (!w_legal) begin
          w_retire = 1'b1;
        end else begin
          case (cu.opcode)
            c_op_branch: begin
              w_sel_pc_a   = 1'b1;
              w_sel_pc_b   = ~w_taken;
              w_load_pc    = 1'b1;
              w_instr_done = 1'b1;
            end
            c_op_jal, c_op_jalr: begin
              w_we_rf      = 1'b1;
              w_sel_rf_in  = c_rf_pc;
              w_sel_pc_rf  = 1'b1;
              w_sel_pc_a   = (cu.opcode == c_op_jal);
              w_load_pc    = 1'b1;
              w_instr_done = 1'b1;
            end
            c_op_auipc: begin
              w_we_rf     = 1'b1;
              w_sel_rf_in = c_rf_pc;
              w_retire    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      c_st_mem: begin
        if (cu.opcode == c_op_store) begin
          w_we_dm  = 1'b1;
          w_retire = 1'b1;
        end
      end
      c_st_wb: begin
        w_we_rf     = 1'b1;
        w_sel_rf_in = (cu.opcode == c_op_load) ? c_rf_dm : c_rf_alu;
        w_retire    = 1'b1;
      end
      c_st_halt: w_illegal = 1'b1;
      default: ;
    endcase

    if (w_retire) begin
      w_sel_pc_a   = 1'b1;
      w_sel_pc_b   = 1'b1;
      w_load_pc    = 1'b1;
      w_instr_done = 1'b1;
    end
  end

  // Enables are forced low during reset so an abandoned instruction cannot write anything
  assign cu.load_IR    = rst_n & w_load_ir;
  assign cu.load_PC    = rst_n & w_load_pc;
  assign cu.we_RF      = rst_n & w_we_rf;
  assign cu.we_DM      = rst_n & w_we_dm;
  assign cu.instr_done = rst_n & w_instr_done;
  assign cu.illegal    = rst_n & w_illegal;
  assign cu.sel_ALU_A  = w_sel_alu_a;
  assign cu.sel_ALU_B  = w_sel_alu_b;
  assign cu.sel_PC_A   = w_sel_pc_a;
  assign cu.sel_PC_B   = w_sel_pc_b;
  assign cu.sel_PC_RF  = w_sel_pc_rf;
  assign cu.sel_imme   = w_sel_imme;
  assign cu.sel_RF_in  = w_sel_rf_in;
  assign cu.alu_op     = w_alu_op;

endmodule

`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle control unit (UC) for the RV64I core. Consumes the datapath's opcode, func3 and ALU branch flags, and sequences a Moore FSM. Drives every datapath load/enable/mux select, plus the data-memory write enable, an ALU operation code and status pulses. Sits beside the datapath as the other end of its control interface.

Parameters:
HALT_ON_ILLEGAL, 1, 1: an unknown opcode/func3 traps to HALT; 0: it retires as a NOP (PC+4).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  IR[6:0] from datapath
func3  input  3  IR[14:12] from datapath
flag_beq, flag_bne, flag_blt, flag_bge, flag_bltu, flag_bgeu  input  1 each  ALU compare flags for rs1 vs rs2
load_IR  output  1  IR <= IM_out
load_PC  output  1  PC <= PC adder result
we_RF  output  1  register file write (rd)
we_DM  output  1  data memory write
sel_ALU_A  output  1  1=rs1, 0=immediate
sel_ALU_B  output  1  1=rs2, 0=immediate
sel_PC_A  output  1  1=PC, 0=rs1
sel_PC_B  output  1  1=constant 4, 0=immediate
sel_PC_RF  output  1  1=PC+4, 0=PC+imm
sel_imme  output  3  000 I, 001 S, 010 B, 011 J, 100 U
sel_RF_in  output  2  00 ALU, 01 DM, 11 PC_RF
alu_op  output  2  00 add, 01 sub, 10 func3/func7-driven, 11 pass B
instr_done  output  1  one-cycle pulse in the last cycle of each instruction
illegal  output  1  high while in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Register updates only on the rising clk edge. Outputs are a combinational function of state, opcode, func3 and flags.
- Reset (rst_n=0 at an edge): state <= FETCH. While rst_n=0, all enables (load_IR, load_PC, we_RF, we_DM, instr_done) are 0 and illegal is 0. Reset mid-instruction abandons that instruction; no partial writes occur after the reset edge.
- Default output values, unless listed below: enables 0, sel_* 0, alu_op 00.
- FETCH: load_IR=1. Next state DECODE.
- DECODE: no enables. Next state EXEC if the opcode is known. Otherwise HALT, or EXEC handled as a NOP if HALT_ON_ILLEGAL=0.
- EXEC, by opcode:
  - R 0110011: sel_ALU_A=1, sel_ALU_B=1, alu_op=10. Next WB.
  - I-ALU 0010011: sel_ALU_A=1, sel_ALU_B=0, sel_imme=000, alu_op=10. Next WB.
  - LOAD 0000011: rs1 + imm I, alu_op=00. Next MEM.
  - STORE 0100011: rs1 + imm S (sel_imme=001), alu_op=00. Next MEM.
  - BRANCH 1100011: sel_ALU_A=1, sel_ALU_B=1, sel_imme=010, sel_PC_A=1, load_PC=1. sel_PC_B=0 if taken, 1 if not. instr_done=1. Next FETCH.
    - Taken select by func3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
    - func3 010/011 is illegal.
  - JAL 1101111: we_RF=1, sel_RF_in=11, sel_PC_RF=1, sel_imme=011, sel_PC_A=1, sel_PC_B=0, load_PC=1, instr_done=1. Next FETCH.
  - JALR 1100111: as JAL but sel_imme=000, sel_PC_A=0. rd==rs1 is safe because the PC adder reads the pre-edge rs1.
  - LUI 0110111: sel_imme=100, sel_ALU_B=0, alu_op=11. Next WB.
  - AUIPC 0010111: sel_imme=100, sel_PC_RF=0, sel_RF_in=11, we_RF=1, sel_PC_A=1, sel_PC_B=1, load_PC=1, instr_done=1. Next FETCH.
- MEM:
  - LOAD: hold the EXEC address selects, one cycle of read latency. Next WB.
  - STORE: hold the EXEC address selects, we_DM=1, sel_PC_A=1, sel_PC_B=1, load_PC=1, instr_done=1. Next FETCH.
- WB: hold the EXEC selects. we_RF=1, sel_RF_in=01 for LOAD, otherwise 00. sel_PC_A=1, sel_PC_B=1, load_PC=1, instr_done=1. Next FETCH.
- Cycle counts:
  - BRANCH, JAL, JALR, AUIPC: 3.
  - R, I-ALU, LUI, STORE: 4.
  - LOAD: 5.
- HALT: illegal=1, all enables 0. Stays in HALT until rst_n=0.
- Invariants:
  - load_PC and we_DM are never high in the same cycle as load_IR.
  - we_RF and we_DM are never high together.
  - Exactly one instr_done pulse per retired instruction.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants;
  - the state encoding (3 bits);
  - the sel_imme, sel_RF_in and alu_op encodings;
  - the branch func3 codes.
- One natural sub-module, branch_cond: combinational mapping of func3 plus the six flags to taken and illegal_func3.

Test Plan:
- Reset: rst_n=0 for 2 cycles with opcode=0110011 -> all enables 0. First cycle after release is FETCH with load_IR=1.
- ADD (opcode 0110011) -> 4 cycles; WB cycle has we_RF=1, sel_RF_in=00, load_PC=1, sel_PC_B=1, instr_done=1.
- LW (0000011) -> 5 cycles; WB has sel_RF_in=01. SW (0100011) -> MEM has we_DM=1, sel_imme=001, and we_RF stays 0 throughout.
- BEQ (func3=000): flag_beq=1 -> EXEC load_PC=1, sel_PC_B=0, sel_imme=010. flag_beq=0 -> sel_PC_B=1. Both take 3 cycles.
- JAL / JALR -> EXEC has we_RF=1, sel_RF_in=11, sel_PC_RF=1, load_PC=1; sel_PC_A is 1 for JAL, 0 for JALR.
- Opcode 1111111 -> HALT after DECODE: illegal=1, no enables for 10 cycles. rst_n=0 -> FETCH. Repeat with HALT_ON_ILLEGAL=0 -> PC+4 retire, instr_done=1.
